// File: rtl/sk6812_pkg.sv
// SK6812 receiver shared definitions: register map,
// STATUS/CTRL bit positions and decoder state encoding.
package sk6812_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_FLEN   = 2'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FRAME = 1;
  localparam int ST_ERR   = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 16;

  localparam int CT_EN        = 0;
  localparam int CT_IRQ_DATA  = 1;
  localparam int CT_IRQ_FRAME = 2;

  typedef enum logic [1:0] {
    S_SYNC      = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_MEAS_HIGH = 2'd2
  } dec_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO; a pop makes room for a
// simultaneous push even when full.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  import sk6812_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_sk6812_rx.sv
// SK6812 single-wire receiver with a Wishbone slave:
// pulse-width decoder, word FIFO, sticky status, IRQ.
module wb_sk6812_rx #(
  parameter int T_THRESH   = 23,
  parameter int T_HMAX     = 75,
  parameter int T_RESET    = 4000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic        din,
  output logic        intr
);
  import sk6812_pkg::*;

  localparam int LW = $clog2(T_RESET + 1);
  localparam int HW = $clog2(T_HMAX + 2);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] L_MAX  = LW'(T_RESET);
  localparam logic [LW-1:0] L_LAST = LW'(T_RESET - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(T_HMAX);
  localparam logic [HW-1:0] H_THR  = HW'(T_THRESH);

  logic [1:0]    sync_q;
  logic          din_s;
  dec_state_t    state, state_d;
  logic [LW-1:0] lcnt, lcnt_d;
  logic [HW-1:0] hcnt, hcnt_d;
  logic          bit_ev, latch, glitch;
  logic [31:0]   sreg;
  logic [4:0]    bcnt;
  logic [7:0]    wcnt, frame_len;
  logic          push_req;
  logic          ovf, err, frame;
  logic [2:0]    ctrl;
  logic          en;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [31:0]   fifo_dout;
  logic          req, wr, rd, pop, wr_status;
  logic [1:0]    adr;
  logic [31:0]   rdata;
  logic          ovf_set, err_set;
  logic          unused;

  assign unused = ^{wb_adr_i[31:4], wb_adr_i[1:0],
                    wb_sel_i, wb_dat_i[31:4]};

  assign din_s     = sync_q[1];
  assign en        = ctrl[CT_EN];
  assign adr       = wb_adr_i[3:2];
  assign req       = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr        = req & wb_we_i;
  assign rd        = req & ~wb_we_i;
  assign wr_status = wr & (adr == REG_STATUS);
  assign pop       = rd & (adr == REG_DATA) & ~fifo_empty;
  assign ovf_set   = push_req & fifo_full & ~pop;
  assign err_set   = glitch | (latch & (bcnt != 5'd0));

  always_comb begin
    state_d = state;
    lcnt_d  = lcnt;
    hcnt_d  = hcnt;
    bit_ev  = 1'b0;
    latch   = 1'b0;
    glitch  = 1'b0;
    unique case (state)
      S_SYNC: begin
        if (din_s) begin
          lcnt_d = '0;
        end else if (lcnt == L_LAST) begin
          // enter idle already saturated: no latch until a pulse
          lcnt_d  = L_MAX;
          state_d = S_WAIT_HIGH;
        end else begin
          lcnt_d = lcnt + LW'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (din_s) begin
          // the edge cycle is the first high cycle
          hcnt_d  = HW'(1);
          lcnt_d  = '0;
          state_d = S_MEAS_HIGH;
        end else if (lcnt != L_MAX) begin
          lcnt_d = lcnt + LW'(1);
          latch  = (lcnt == L_LAST);
        end
      end
      S_MEAS_HIGH: begin
        if (!din_s) begin
          bit_ev  = 1'b1;
          lcnt_d  = LW'(1);
          state_d = S_WAIT_HIGH;
        end else if (hcnt == H_MAX) begin
          glitch  = 1'b1;
          lcnt_d  = '0;
          state_d = S_SYNC;
        end else begin
          hcnt_d = hcnt + HW'(1);
        end
      end
      default: state_d = S_SYNC;
    endcase
    if (!en) begin
      state_d = S_SYNC;
      lcnt_d  = '0;
      hcnt_d  = '0;
      bit_ev  = 1'b0;
      latch   = 1'b0;
      glitch  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_SYNC;
      lcnt  <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_d;
      lcnt  <= lcnt_d;
      hcnt  <= hcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q    <= '0;
      sreg      <= '0;
      bcnt      <= '0;
      wcnt      <= '0;
      frame_len <= '0;
      push_req  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], din};
      push_req <= 1'b0;
      if (!en) begin
        sreg <= '0;
        bcnt <= '0;
        wcnt <= '0;
      end else if (latch) begin
        frame_len <= wcnt;
        wcnt      <= '0;
        bcnt      <= '0;
        sreg      <= '0;
      end else if (glitch) begin
        bcnt <= '0;
        sreg <= '0;
      end else if (bit_ev) begin
        sreg <= {sreg[30:0], hcnt >= H_THR};
        if (bcnt == 5'd31) begin
          bcnt     <= '0;
          push_req <= 1'b1;
          if (wcnt != 8'hFF) wcnt <= wcnt + 8'd1;
        end else begin
          bcnt <= bcnt + 5'd1;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdata (sreg),
    .rdata (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      adr == REG_DATA:
        rdata = fifo_empty ? '0 : fifo_dout;
      adr == REG_STATUS: begin
        rdata[ST_CNT +: 4] = 4'(fifo_cnt);
        rdata[ST_OVF]      = ovf;
        rdata[ST_ERR]      = err;
        rdata[ST_FRAME]    = frame;
        rdata[ST_EMPTY]    = fifo_empty;
      end
      adr == REG_CTRL:
        rdata[2:0] = ctrl;
      default:
        rdata[7:0] = frame_len;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      ctrl     <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      frame    <= 1'b0;
      intr     <= 1'b0;
    end else begin
      wb_ack_o <= req;
      if (rd)      wb_dat_o <= rdata;
      else if (wr) wb_dat_o <= '0;
      if (wr && adr == REG_CTRL) ctrl <= wb_dat_i[2:0];
      ovf   <= (ovf & ~(wr_status & wb_dat_i[ST_OVF]))
               | ovf_set;
      err   <= (err & ~(wr_status & wb_dat_i[ST_ERR]))
               | err_set;
      frame <= (frame & ~(wr_status & wb_dat_i[ST_FRAME]))
               | latch;
      intr  <= (ctrl[CT_IRQ_DATA] & ~fifo_empty)
               | (ctrl[CT_IRQ_FRAME] & frame);
    end
  end

endmodule
